// File: rtl/fu_div_iter.sv
// Iterative integer divide unit: restoring radix-2, one quotient bit per cycle.
// Divide-by-zero and signed overflow resolve at issue without iterating.
module fu_div_iter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0]  ZERO_C    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONES_C    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  MIN_C     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [TAG_W-1:0] TAG_ZERO_C = {TAG_W{1'b0}};
  localparam logic [CW-1:0]    CNT_ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    LAST_C     = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_t            state_r, state_nx_s;
  logic [CW-1:0]     cnt_r;
  logic [1:0]        op_r;
  logic [TAG_W-1:0]  tag_r;
  logic              neg_q_r, neg_r_r;
  logic [XLEN-1:0]   dvs_r, quot_r, rem_r;
  logic [XLEN-1:0]   out_data_r;
  logic [TAG_W-1:0]  out_tag_r;

  logic              accept_s, retire_s, sgn_s, a_neg_s, b_neg_s;
  logic              dz_s, ovf_s, special_s, ge_s, last_s;
  logic [XLEN-1:0]   spec_data_s, diff_s, rem_nx_s, quot_nx_s, fin_data_s;
  logic [XLEN:0]     shift_s;

  // Handshake, FSM next state and status outputs
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    state_nx_s = state_r;
    in_ready   = !flush && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
    out_valid  = (state_r == DONE);
    busy       = (state_r != IDLE);
    accept_s   = in_valid && in_ready;
    retire_s   = out_valid && out_ready;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nx_s = special_s ? DONE : CALC;
        else          state_nx_s = IDLE;
      end
      CALC: begin
        if (last_s) state_nx_s = DONE;
        else        state_nx_s = CALC;
      end
      DONE: begin
        if (accept_s)      state_nx_s = special_s ? DONE : CALC;
        else if (retire_s) state_nx_s = IDLE;
        else               state_nx_s = DONE;
      end
      default: state_nx_s = IDLE;
    endcase
    if (flush) state_nx_s = IDLE;
    else       state_nx_s = state_nx_s;
  end

  // Operand classification and the special-case result chosen at issue
  always_comb begin
    sgn_s       = !in_op[0];
    a_neg_s     = sgn_s && in_rs1[XLEN-1];
    b_neg_s     = sgn_s && in_rs2[XLEN-1];
    dz_s        = (in_rs2 == ZERO_C);
    ovf_s       = sgn_s && (in_rs1 == MIN_C) && (in_rs2 == ONES_C);
    special_s   = dz_s || ovf_s;
    spec_data_s = ZERO_C;
    if (in_op[1]) spec_data_s = dz_s ? in_rs1 : ZERO_C;
    else          spec_data_s = dz_s ? ONES_C : in_rs1;
  end

  // One restoring step on magnitudes, plus the sign-fixed final result
  always_comb begin
    shift_s    = {rem_r, quot_r[XLEN-1]};
    ge_s       = (shift_s >= {1'b0, dvs_r});
    // when the subtract succeeds the difference is below the divisor, so XLEN bits suffice
    diff_s     = shift_s[XLEN-1:0] - dvs_r;
    rem_nx_s   = ge_s ? diff_s : shift_s[XLEN-1:0];
    quot_nx_s  = {quot_r[XLEN-2:0], ge_s};
    last_s     = (cnt_r == LAST_C);
    fin_data_s = ZERO_C;
    if (op_r[1]) fin_data_s = neg_if(rem_nx_s, neg_r_r);
    else         fin_data_s = neg_if(quot_nx_s, neg_q_r);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx_s;
  end

  // Datapath: capture at issue, iterate in CALC, publish on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO_C;  op_r <= 2'b00;  tag_r <= TAG_ZERO_C;
      neg_q_r <= 1'b0;  neg_r_r <= 1'b0;
      dvs_r <= ZERO_C;  quot_r <= ZERO_C;  rem_r <= ZERO_C;
      out_data_r <= ZERO_C;  out_tag_r <= TAG_ZERO_C;
    end else if (flush) begin
      cnt_r <= CNT_ZERO_C;  out_data_r <= ZERO_C;  out_tag_r <= TAG_ZERO_C;
    end else if (accept_s) begin
      cnt_r      <= CNT_ZERO_C;
      op_r       <= in_op;
      tag_r      <= in_tag;
      neg_q_r    <= a_neg_s ^ b_neg_s;
      neg_r_r    <= a_neg_s;
      dvs_r      <= neg_if(in_rs2, b_neg_s);
      quot_r     <= neg_if(in_rs1, a_neg_s);
      rem_r      <= ZERO_C;
      out_data_r <= special_s ? spec_data_s : ZERO_C;
      out_tag_r  <= special_s ? in_tag : TAG_ZERO_C;
    end else if (state_r == CALC) begin
      quot_r <= quot_nx_s;
      rem_r  <= rem_nx_s;
      cnt_r  <= cnt_r + CNT_ONE_C;
      if (last_s) begin
        out_data_r <= fin_data_s;
        out_tag_r  <= tag_r;
      end
    end else if (retire_s) begin
      out_data_r <= ZERO_C;
      out_tag_r  <= TAG_ZERO_C;
    end
  end

  assign out_data = out_data_r;
  assign out_tag  = out_tag_r;
endmodule

// File: tb/tb_fu_div_iter.sv
// Bench for fu_div_iter (XLEN=32): transaction-level reference model checked every cycle,
// directed vectors with literal expectations, then a random run with stalls and flushes.
module tb_fu_div_iter;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [1:0]  in_op;
  logic [31:0] in_rs1, in_rs2, out_data;
  logic [4:0]  in_tag, out_tag;

  fu_div_iter #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, n_ret = 0;
  int acc_cyc = 0, obs_first = 0, last_lat = 0, mdl_due = 0;
  logic mdl_busy = 1'b0, seen_valid = 1'b0, exp_valid, exp_rdy;
  logic [31:0] mdl_data = 32'd0, last_data = 32'd0;
  logic [4:0]  mdl_tag = 5'd0, last_tag = 5'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin q = 32'hFFFF_FFFF; r = a; end
    else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = a; r = 32'd0; end
    else if (!op[0]) begin q = 32'($signed(a) / $signed(b)); r = 32'($signed(a) % $signed(b)); end
    else begin q = a / b; r = a % b; end
    return op[1] ? r : q;
  endfunction

  // Compare process: one unit-level transaction in flight, result due a fixed latency after issue
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_in_ready", in_ready, !flush);
      mdl_busy = 1'b0; seen_valid = 1'b0;
    end else begin
      exp_valid = mdl_busy && (cyc >= mdl_due);
      exp_rdy   = !flush && (!mdl_busy || (exp_valid && out_ready));
      chk("out_valid", out_valid, exp_valid);
      chk("busy", busy, mdl_busy);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_data", out_data, exp_valid ? mdl_data : 32'd0);
      chk("out_tag", out_tag, exp_valid ? mdl_tag : 5'd0);
      if (out_valid && !seen_valid) begin seen_valid = 1'b1; obs_first = cyc; end
      if (flush) begin
        mdl_busy = 1'b0; seen_valid = 1'b0;
      end else begin
        if (exp_valid && out_ready) begin
          mdl_busy = 1'b0; seen_valid = 1'b0; n_ret++;
          last_data = out_data; last_tag = out_tag; last_lat = obs_first - acc_cyc;
        end
        if (in_valid && exp_rdy) begin
          mdl_busy = 1'b1;
          mdl_data = ref_res(in_op, in_rs1, in_rs2);
          mdl_tag  = in_tag;
          mdl_due  = cyc + (is_special(in_op, in_rs1, in_rs2) ? 1 : 33);
          acc_cyc  = cyc;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int n = 0;
    @(posedge clk); #1;
    in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag; in_valid = 1'b1;
    @(negedge clk);
    while (!(in_ready && !flush) && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) begin total++; bad++; $display("FAIL issue_timeout: no accept within 200 cycles"); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int start = n_ret;
    int n = 0;
    while (n_ret == start && n < 200) begin @(negedge clk); n++; end
    if (n_ret == start) begin total++; bad++; $display("FAIL result_timeout: no retire within 200 cycles"); end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp_data, input int exp_lat);
    issue(op, a, b, tag);
    wait_result();
    chk({name, "_data"}, last_data, exp_data);
    chk({name, "_tag"}, last_tag, tag);
    chk({name, "_lat"}, last_lat, exp_lat);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    logic acc_last;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_rs1 = 32'd0; in_rs2 = 32'd0;
    in_tag = 5'd0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("init_in_ready", in_ready, 1);
    chk("init_out_valid", out_valid, 0);
    chk("init_busy", busy, 0);

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd3, 32'd14, 33);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd3, 32'd2, 33);
    run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 33);
    run_op("div_7_m2",   2'b00, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'hFFFF_FFFD, 33);
    run_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 5'd5, 32'd1, 33);
    run_op("divu_5_0",   2'b01, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 1);
    run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'd0, 1);
    run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1);

    // Writeback stall, then retire and issue on the same edge
    out_ready = 1'b0;
    issue(2'b01, 32'd50, 32'd5, 5'd7);
    saved = 0;
    while (!out_valid && saved < 100) begin @(negedge clk); saved++; end
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 32'd10);
      chk("stall_tag", out_tag, 5'd7);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_op = 2'b01; in_rs1 = 32'd9; in_rs2 = 32'd3; in_tag = 5'd9;
    @(negedge clk);
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_busy", busy, 1);
    chk("b2b_retired_data", last_data, 32'd10);
    wait_result();
    chk("b2b_new_data", last_data, 32'd3);
    chk("b2b_new_tag", last_tag, 5'd9);

    // Flush in the tenth CALC cycle with a competing issue request
    issue(2'b01, 32'd1000, 32'd3, 5'd4);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1; in_valid = 1'b1; in_op = 2'b01; in_rs1 = 32'd8; in_rs2 = 32'd2; in_tag = 5'd5;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_in_ready", in_ready, 1);
    chk("post_flush_valid", out_valid, 0);
    saved = n_ret;
    repeat (40) @(negedge clk);
    chk("flush_no_result", n_ret, saved);
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 5'd6, 32'd3, 33);

    // Asynchronous reset in the middle of CALC
    issue(2'b01, 32'd12345, 32'd7, 5'd2);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_data", out_data, 0);
    @(negedge clk); @(posedge clk); #1 rst_n = 1'b1;
    saved = n_ret;
    repeat (40) @(negedge clk);
    chk("rst_no_result", n_ret, saved);
    run_op("post_rst_rem", 2'b10, 32'hFFFF_FF9C, 32'd7, 5'd11, 32'hFFFF_FFFE, 33);

    // Random traffic: held requests, writeback stalls, occasional flush
    acc_last = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!in_valid || acc_last) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = 2'($urandom_range(0, 3));
        in_rs1   = pick();
        in_rs2   = pick();
        in_tag   = 5'($urandom_range(0, 31));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      acc_last = in_valid && in_ready;
    end
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (60) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
